// File: rtl/multi_shift_reg_pkg.sv
// multi_shift_reg_pkg: mode encoding, FSM states and shift classification for multi_shift_reg
package multi_shift_reg_pkg;
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  function automatic logic is_shift(input logic [2:0] m);
    return m inside {M_SHL, M_SHR, M_ROTL, M_ROTR, M_ASR};
  endfunction
endpackage

// File: rtl/multi_shift_reg_shift_step.sv
// shift_step: one combinational register step (load/shift/rotate/asr) plus the bit leaving the register
module shift_step import multi_shift_reg_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] nq,
  output logic             so
);
  // next value per mode; the out bit is the MSB for left moves and the LSB otherwise
  always_comb begin
    nq = mode == M_LOAD ? d :
         mode == M_SHL  ? {q[WIDTH-2:0], sin} :
         mode == M_SHR  ? {sin, q[WIDTH-1:1]} :
         mode == M_ROTL ? {q[WIDTH-2:0], q[WIDTH-1]} :
         mode == M_ROTR ? {q[0], q[WIDTH-1:1]} :
         mode == M_ASR  ? {q[WIDTH-1], q[WIDTH-1:1]} : q;
    so = (mode == M_SHL || mode == M_ROTL) ? q[WIDTH-1] : q[0];
  end
endmodule

// File: rtl/multi_shift_reg.sv
// multi_shift_reg: shift register with direct single steps and a counted multi-step FSM
module multi_shift_reg import multi_shift_reg_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             S,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  input  logic             START,
  input  logic [CNT_W-1:0] AMT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);
  state_t           state;
  logic [2:0]       op_q;
  logic [2:0]       step_mode;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] nq;
  logic             so;
  assign step_mode = state == SHIFT ? op_q : MODE;
  assign Qn = ~Q;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .q   (Q),
    .mode(step_mode),
    .sin (SIN),
    .d   (D),
    .nq  (nq),
    .so  (so)
  );
  // reset beats preset beats the FSM; a preset mid-run aborts silently and keeps SOUT
  always_ff @(posedge C) begin
    if (R) begin
      Q     <= '0;
      SOUT  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      cnt   <= '0;
      op_q  <= M_HOLD;
      state <= IDLE;
    end else if (S) begin
      Q     <= '1;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            op_q  <= MODE;
            cnt   <= AMT;
            state <= AMT != '0 ? SHIFT : FIN;
            BUSY  <= AMT != '0;
            DONE  <= AMT == '0;
          end else if (EN) begin
            Q    <= nq;
            SOUT <= is_shift(MODE) ? so : SOUT;
          end
        end
        SHIFT: begin
          if (EN) begin
            Q    <= nq;
            SOUT <= is_shift(op_q) ? so : SOUT;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end
        end
        default: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multi_shift_reg.sv
// tb_multi_shift_reg: scoreboard-driven checks of reset, direct steps, multi-step runs, stalls and aborts
module tb_multi_shift_reg;
  logic       C = 0, R = 0, S = 0, EN = 0, SIN = 0, START = 0;
  logic [2:0] MODE = 0;
  logic [7:0] D = 0;
  logic [3:0] AMT = 0;
  logic [7:0] Q, Qn;
  logic       SOUT, BUSY, DONE;
  int         passed = 0, total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  int         busy_n, done_n;

  multi_shift_reg #(.WIDTH(8)) dut (
    .C(C), .R(R), .S(S), .EN(EN), .MODE(MODE), .D(D), .SIN(SIN),
    .START(START), .AMT(AMT), .Q(Q), .Qn(Qn), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    MODE = 3'b001; D = v; EN = 1; tick();
    MODE = 3'b000; EN = 0;
  endtask

  task automatic test_reset();
    R = 1; S = 1; EN = 1; MODE = 3'b001; D = 8'h55; START = 1; AMT = 4'd3;
    tick();
    R = 0; S = 0; EN = 0; MODE = 0; START = 0; AMT = 0;
    total++; if (Q !== 8'h00) $display("FAIL reset_q: got %h want 00", Q); else passed++;
    total++; if (Qn !== 8'hFF) $display("FAIL reset_qn: got %h want FF", Qn); else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else passed++;
    total++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", DONE); else passed++;
    total++; if (SOUT !== 1'b0) $display("FAIL reset_sout: got %b want 0", SOUT); else passed++;
  endtask

  task automatic test_direct_shl();
    load(8'hA5);
    exp_q.push_back(8'h4A);
    MODE = 3'b010; SIN = 0; EN = 1; tick();
    e = exp_q.pop_front();
    total++; if (Q !== e) $display("FAIL shl_q: got %h want %h", Q, e); else passed++;
    total++; if (SOUT !== 1'b1) $display("FAIL shl_sout: got %b want 1", SOUT); else passed++;
    total++; if (Qn !== ~e) $display("FAIL shl_qn: got %h want %h", Qn, ~e); else passed++;
    EN = 0; tick();
    total++; if (Q !== 8'h4A) $display("FAIL hold_q: got %h want 4A", Q); else passed++;
    MODE = 0;
  endtask

  task automatic test_rotr();
    load(8'h81);
    exp_q.push_back(8'hC0); exp_q.push_back(8'h60); exp_q.push_back(8'h30);
    START = 1; MODE = 3'b101; AMT = 4'd3; EN = 1; tick();
    START = 0; MODE = 3'b010; AMT = 4'd9;
    total++; if (Q !== 8'h81) $display("FAIL rotr_start_q: got %h want 81", Q); else passed++;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      if (BUSY) busy_n++;
      tick();
      if (DONE) done_n++;
      e = exp_q.pop_front();
      total++; if (Q !== e) $display("FAIL rotr_step%0d: got %h want %h", i, Q, e); else passed++;
    end
    total++; if (DONE !== 1'b1) $display("FAIL rotr_done: got %b want 1", DONE); else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL rotr_busy_end: got %b want 0", BUSY); else passed++;
    total++; if (SOUT !== 1'b0) $display("FAIL rotr_sout: got %b want 0", SOUT); else passed++;
    total++; if (busy_n != 3) $display("FAIL rotr_busy_cycles: got %0d want 3", busy_n); else passed++;
    EN = 0; MODE = 0; AMT = 0; tick();
    total++; if (DONE !== 1'b0) $display("FAIL rotr_done_pulse: got %b want 0", DONE); else passed++;
    total++; if (Q !== 8'h30) $display("FAIL rotr_final: got %h want 30", Q); else passed++;
  endtask

  task automatic test_asr_stall();
    load(8'h90);
    exp_q.push_back(8'hC8); exp_q.push_back(8'hE4); exp_q.push_back(8'hF2); exp_q.push_back(8'hF9);
    START = 1; MODE = 3'b110; AMT = 4'd4; EN = 1; tick();
    START = 0; MODE = 3'b001; D = 8'h00;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      EN = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      if (BUSY) busy_n++;
      tick();
      if (DONE) done_n++;
      if (EN) begin
        e = exp_q.pop_front();
        total++; if (Q !== e) $display("FAIL asr_step%0d: got %h want %h", i, Q, e); else passed++;
      end else begin
        total++; if (BUSY !== 1'b1) $display("FAIL asr_stall%0d_busy: got %b want 1", i, BUSY); else passed++;
      end
    end
    EN = 0; MODE = 0;
    total++; if (Q !== 8'hF9) $display("FAIL asr_final: got %h want F9", Q); else passed++;
    total++; if (busy_n != 6) $display("FAIL asr_busy_cycles: got %0d want 6", busy_n); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (DONE) done_n++;
    end
    total++; if (done_n != 1) $display("FAIL asr_done_pulses: got %0d want 1", done_n); else passed++;
  endtask

  task automatic test_amt_zero();
    load(8'h3C);
    exp_q.push_back(8'h3C);
    START = 1; MODE = 3'b010; AMT = 4'd0; EN = 1; tick();
    START = 0; EN = 0; MODE = 0;
    e = exp_q.pop_front();
    total++; if (DONE !== 1'b1) $display("FAIL amt0_done: got %b want 1", DONE); else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL amt0_busy: got %b want 0", BUSY); else passed++;
    total++; if (Q !== e) $display("FAIL amt0_q: got %h want %h", Q, e); else passed++;
    tick();
    total++; if (DONE !== 1'b0) $display("FAIL amt0_done_clear: got %b want 0", DONE); else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL amt0_busy_after: got %b want 0", BUSY); else passed++;
    total++; if (Q !== e) $display("FAIL amt0_q_after: got %h want %h", Q, e); else passed++;
  endtask

  task automatic test_preset_abort();
    load(8'h0F);
    exp_q.push_back(8'h1E); exp_q.push_back(8'h3C);
    START = 1; MODE = 3'b010; AMT = 4'd5; EN = 1; SIN = 0; tick();
    START = 0; MODE = 0;
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      total++; if (Q !== e) $display("FAIL abort_step%0d: got %h want %h", i, Q, e); else passed++;
    end
    S = 1; tick();
    S = 0; EN = 0;
    total++; if (Q !== 8'hFF) $display("FAIL abort_q: got %h want FF", Q); else passed++;
    total++; if (BUSY !== 1'b0) $display("FAIL abort_busy: got %b want 0", BUSY); else passed++;
    total++; if (DONE !== 1'b0) $display("FAIL abort_done: got %b want 0", DONE); else passed++;
    total++; if (SOUT !== 1'b0) $display("FAIL abort_sout: got %b want 0", SOUT); else passed++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (DONE) done_n++;
      if (BUSY) busy_n++;
    end
    total++; if (done_n != 0) $display("FAIL abort_no_done: got %0d want 0", done_n); else passed++;
    total++; if (busy_n != 0) $display("FAIL abort_no_busy: got %0d want 0", busy_n); else passed++;
    MODE = 3'b011; SIN = 0; EN = 1; tick();
    EN = 0; MODE = 0;
    total++; if (Q !== 8'h7F) $display("FAIL abort_idle_direct: got %h want 7F", Q); else passed++;
    total++; if (SOUT !== 1'b1) $display("FAIL abort_idle_sout: got %b want 1", SOUT); else passed++;
  endtask

  initial begin
    test_reset();
    test_direct_shl();
    test_rotr();
    test_asr_stall();
    test_amt_zero();
    test_preset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multi_shift_reg.md
MULTI_SHIFT_REG -- requirements
Module: multi_shift_reg

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the register width in bits; legal range 2..32.
REQ-002 The block SHALL take parameter CNT_W, default $clog2(WIDTH)+1, as the shift-amount width; it is derived and never overridden.
REQ-003 The block SHALL provide port C, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port R, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL provide port S, input, 1 bit: synchronous preset, active-high.
REQ-006 The block SHALL provide port EN, input, 1 bit: step enable.
REQ-007 The block SHALL provide port MODE, input, 3 bits: operation select.
REQ-008 The block SHALL provide port D, input, WIDTH bits: parallel load data.
REQ-009 The block SHALL provide port SIN, input, 1 bit: serial fill bit.
REQ-010 The block SHALL provide port START, input, 1 bit: request a multi-step operation.
REQ-011 The block SHALL provide port AMT, input, CNT_W bits: number of steps for START.
REQ-012 The block SHALL provide port Q, output, WIDTH bits: register contents.
REQ-013 The block SHALL provide port Qn, output, WIDTH bits: bitwise complement of Q, driven combinationally.
REQ-014 The block SHALL provide port SOUT, output, 1 bit: the bit shifted out by the most recent step.
REQ-015 The block SHALL provide port BUSY, output, 1 bit: high while a multi-step operation runs.
REQ-016 The block SHALL provide port DONE, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 MODE SHALL encode:
- 000 hold
- 001 load D
- 010 shl, SIN into LSB
- 011 shr, SIN into MSB
- 100 rotl
- 101 rotr
- 110 asr, MSB replicated
- 111 hold (reserved)
REQ-018 Edge priority SHALL be R > S > FSM; when R and S are both high, R wins.
REQ-019 The FSM SHALL have three states: IDLE, SHIFT, FIN.
REQ-020 In IDLE with START=0 and EN=1, the block SHALL apply MODE once per edge (direct mode); with EN=0, Q SHALL hold.
REQ-021 In IDLE with START=1 (EN ignored), the block SHALL latch MODE into op_q and AMT into cnt, leave Q unchanged, and go to SHIFT if AMT>0, else to FIN.
REQ-022 In SHIFT, each edge with EN=1 SHALL apply op_q once and decrement cnt; when cnt goes 1->0 the FSM SHALL go to FIN.
REQ-023 In SHIFT with EN=0, Q and cnt SHALL hold (stall).
REQ-024 In SHIFT, MODE, START and AMT SHALL be ignored; load mode SHALL reload D on every step.
REQ-025 FIN SHALL last exactly one cycle with DONE=1, then return to IDLE; START in FIN SHALL be ignored.
REQ-026 BUSY SHALL be 1 exactly while in SHIFT.
REQ-027 SOUT SHALL update only on shift or rotate steps: Q[WIDTH-1] before the step for shl/rotl, Q[0] for shr/rotr/asr; otherwise it holds.
REQ-028 Total latency from the START edge to DONE high SHALL be AMT enabled SHIFT cycles plus one.

Reset
REQ-029 On R=1 at an edge, the block SHALL set Q=0, Qn=all ones, SOUT=0, BUSY=0, DONE=0, cnt=0, op_q=000, and state IDLE, regardless of any other input.
REQ-030 On S=1 (R=0) at an edge, the block SHALL set Q=all ones, state IDLE, BUSY=0, DONE=0, and leave SOUT unchanged.
REQ-031 An R or S asserted during SHIFT SHALL abort the operation with no DONE pulse.

Structure
REQ-032 Package multi_shift_reg_pkg SHALL hold the MODE constants and the FSM state encoding.
REQ-033 The one-step shifter SHALL be a combinational sub-module shift_step (inputs Q, mode, SIN, D; outputs next Q, out bit), shared by direct and FSM paths.

Verification (WIDTH=8)
REQ-034 The bench SHALL drive R=1,S=1 for one edge and check Q=00, Qn=FF, BUSY=0, DONE=0.
REQ-035 The bench SHALL load A5, apply direct shl with SIN=0 for one edge, and check Q=4A, SOUT=1.
REQ-036 The bench SHALL load 81, START rotr AMT=3 with EN=1, and check: BUSY high 3 cycles; Q steps C0, 60, 30; DONE high for one cycle after the last step; SOUT=0.
REQ-037 The bench SHALL load 90, START asr AMT=4 with EN low for 2 cycles mid-run, and check BUSY high 6 cycles, final Q=F9, one DONE pulse.
REQ-038 The bench SHALL START with AMT=0 and check DONE high the next cycle, BUSY never high, Q unchanged.
REQ-039 The bench SHALL START shl AMT=5, assert S after 2 steps, and check Q=FF, state IDLE, BUSY=0, no DONE pulse.
